// File: rtl/reg_mem_pkg.sv
// Shared types and address helpers for the banked register memory.
// Addresses are low-order interleaved: the low bits pick the bank and the rest pick the row.
package reg_mem_pkg;

    typedef enum logic {
        RDW_OLD = 1'b0,
        RDW_NEW = 1'b1
    } rdw_mode_e;

    function automatic int unsigned bytes_of(input int unsigned width);
        return width / 8;
    endfunction

    function automatic int unsigned addr_bank(input int unsigned addr,
                                              input int unsigned bank_bits);
        return addr & ((32'd1 << bank_bits) - 32'd1);
    endfunction

    function automatic int unsigned addr_row(input int unsigned addr,
                                             input int unsigned addr_w,
                                             input int unsigned bank_bits);
        return (addr & ((32'd1 << addr_w) - 32'd1)) >> bank_bits;
    endfunction

endpackage

// File: rtl/reg_mem_bank_arb.sv
// Round-robin arbiter for one bank: grants the first requester at or after the pointer.
// The pointer only advances on contested grants, so an uncontested port never disturbs fairness.
module reg_mem_bank_arb #(
    parameter int PORTS = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [PORTS-1:0] req_i,
    output logic [PORTS-1:0] grant_o
);

    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PTR_W-1:0] rr_reg;
    logic [PTR_W-1:0] rr_next;
    logic [PTR_W-1:0] winner;
    logic             found;
    int unsigned      idx;
    int unsigned      req_count;

    always_comb begin
        grant_o   = '0;
        winner    = '0;
        found     = 1'b0;
        idx       = 0;
        req_count = 0;
        for (int i = 0; i < PORTS; i++) begin
            idx = (32'(rr_reg) + unsigned'(i)) % PORTS;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                winner       = PTR_W'(idx);
            end
            if (req_i[i]) begin
                req_count = req_count + 1;
            end
        end
        rr_next = rr_reg;
        if (req_count >= 2) begin
            rr_next = (winner == PTR_W'(PORTS - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_reg <= '0;
        end else begin
            rr_reg <= rr_next;
        end
    end

endmodule

// File: rtl/reg_mem_banked.sv
// Multi-port banked register memory with per-bank round-robin arbitration,
// byte-enable writes, selectable same-port read-during-write and registered reads.
module reg_mem_banked
    import reg_mem_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int HEIGHT  = 64,
    parameter int PORTS   = 2,
    parameter int BANKS   = 4,
    parameter int RDW_NEW = 0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [PORTS-1:0]                       enable_i,
    input  logic [PORTS-1:0]                       writeEnable_i,
    input  logic [PORTS-1:0][$clog2(HEIGHT)-1:0]   addr_i,
    input  logic [PORTS-1:0][WIDTH-1:0]            writeData_i,
    input  logic [PORTS-1:0][WIDTH/8-1:0]          byteEn_i,
    output logic [PORTS-1:0][WIDTH-1:0]            readData_o,
    output logic [PORTS-1:0]                       readValid_o,
    output logic [PORTS-1:0]                       hold_o
);

    localparam int        AW        = $clog2(HEIGHT);
    localparam int        BANK_BITS = $clog2(BANKS);
    localparam int        BANK_W    = (BANKS > 1) ? BANK_BITS : 1;
    localparam int        ROWS      = HEIGHT / BANKS;
    localparam int        ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int        BYTES     = int'(bytes_of(WIDTH));
    localparam rdw_mode_e RDW_MODE  = rdw_mode_e'(RDW_NEW != 0);

    logic [PORTS-1:0]              req;
    logic [PORTS-1:0]              port_grant;
    logic [BANK_W-1:0]             bank_sel [PORTS];
    logic [ROW_W-1:0]              row_sel  [PORTS];
    logic [WIDTH-1:0]              old_word [PORTS];
    logic [WIDTH-1:0]              new_word [PORTS];
    logic [BANKS-1:0][PORTS-1:0]   bank_grant;
    logic [WIDTH-1:0]              mem [BANKS][ROWS];
    logic [PORTS-1:0][WIDTH-1:0]   rdata_reg;
    logic [PORTS-1:0]              rvalid_reg;

    genvar gi;

    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_port
            logic [WIDTH-1:0] merged;

            assign req[gi]      = enable_i[gi] | writeEnable_i[gi];
            assign bank_sel[gi] = BANK_W'(addr_bank(32'(addr_i[gi]), BANK_BITS));
            assign row_sel[gi]  = ROW_W'(addr_row(32'(addr_i[gi]), AW, BANK_BITS));
            assign old_word[gi] = mem[bank_sel[gi]][row_sel[gi]];

            // The merged word feeds both the write path and the RDW_NEW read path.
            always_comb begin
                merged = old_word[gi];
                for (int k = 0; k < BYTES; k++) begin
                    if (byteEn_i[gi][k]) begin
                        merged[8*k +: 8] = writeData_i[gi][8*k +: 8];
                    end
                end
            end

            assign new_word[gi]   = merged;
            assign port_grant[gi] = bank_grant[bank_sel[gi]][gi];
        end

        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            logic [PORTS-1:0] breq;
            logic [PORTS-1:0] bgnt;

            always_comb begin
                breq = '0;
                for (int p = 0; p < PORTS; p++) begin
                    breq[p] = req[p] && (bank_sel[p] == BANK_W'(gi));
                end
            end

            reg_mem_bank_arb #(
                .PORTS (PORTS)
            ) u_arb (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .req_i   (breq),
                .grant_o (bgnt)
            );

            assign bank_grant[gi] = bgnt;
        end
    endgenerate

    // At most one port is granted per bank, so the port writes never collide.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int p = 0; p < PORTS; p++) begin
                if (port_grant[p] && writeEnable_i[p]) begin
                    mem[bank_sel[p]][row_sel[p]] <= new_word[p];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_reg  <= '0;
            rvalid_reg <= '0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                rvalid_reg[p] <= port_grant[p] & enable_i[p];
                if (port_grant[p] && enable_i[p]) begin
                    if (RDW_MODE != RDW_OLD && writeEnable_i[p]) begin
                        rdata_reg[p] <= new_word[p];
                    end else begin
                        rdata_reg[p] <= old_word[p];
                    end
                end
            end
        end
    end

    assign readData_o  = rdata_reg;
    assign readValid_o = rvalid_reg;
    assign hold_o      = req & ~port_grant & {PORTS{~rst_i}};

endmodule

// File: tb/tb_reg_mem_banked.sv
// Directed bench for reg_mem_banked: two instances (old / new read-during-write) share stimulus,
// reads are scoreboarded against a bench memory model.
module tb_reg_mem_banked;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       en;
    logic [1:0]       we;
    logic [1:0][5:0]  addr;
    logic [1:0][31:0] wdata;
    logic [1:0][3:0]  ben;
    logic [1:0][31:0] rdata0, rdata1;
    logic [1:0]       rvalid0, rvalid1, hold0, hold1;

    typedef struct {
        int          port;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } sb_item_t;

    sb_item_t         sb[$];
    logic [31:0]      model [64];
    logic [1:0][31:0] last0, last1;
    int               checks   = 0;
    int               failures = 0;

    always #5 clk = ~clk;

    reg_mem_banked #(.WIDTH(32), .HEIGHT(64), .PORTS(2), .BANKS(4), .RDW_NEW(0)) u_dut_old (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .writeEnable_i(we), .addr_i(addr),
        .writeData_i(wdata), .byteEn_i(ben), .readData_o(rdata0), .readValid_o(rvalid0),
        .hold_o(hold0)
    );

    reg_mem_banked #(.WIDTH(32), .HEIGHT(64), .PORTS(2), .BANKS(4), .RDW_NEW(1)) u_dut_new (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .writeEnable_i(we), .addr_i(addr),
        .writeData_i(wdata), .byteEn_i(ben), .readData_o(rdata1), .readValid_o(rvalid1),
        .hold_o(hold1)
    );

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = n[8*k +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h required=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] exp_valid);
        sb_item_t it;
        chk({tag, "/valid_old"}, 32'(rvalid0), 32'(exp_valid));
        chk({tag, "/valid_new"}, 32'(rvalid1), 32'(exp_valid));
        for (int p = 0; p < 2; p++) begin
            if (rvalid0[p]) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL %s/sb_pop port %0d: observed valid=1 required no valid (nothing pending)", tag, p);
                end
                if (sb.size() != 0) begin
                    it = sb.pop_front();
                    last0[p] = it.exp0;
                    last1[p] = it.exp1;
                end
            end
            chk($sformatf("%s/rdata_old%0d", tag, p), rdata0[p], last0[p]);
            chk($sformatf("%s/rdata_new%0d", tag, p), rdata1[p], last1[p]);
        end
        $display("step %s: hold=%b valid=%b rdata0=%h rdata1=%h", tag, hold0, rvalid0, rdata0[0], rdata0[1]);
    endtask

    task automatic cycle(input string tag, input logic [1:0] en_v, input logic [1:0] we_v,
                         input logic [5:0] a0, input logic [5:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [3:0] b0, input logic [3:0] b1,
                         input logic [1:0] exp_hold);
        logic [1:0] served;
        sb_item_t   it;
        rst = 1'b0; en = en_v; we = we_v;
        addr[0] = a0; addr[1] = a1; wdata[0] = d0; wdata[1] = d1; ben[0] = b0; ben[1] = b1;
        #1;
        chk({tag, "/hold_old"}, 32'(hold0), 32'(exp_hold));
        chk({tag, "/hold_new"}, 32'(hold1), 32'(exp_hold));
        served = (en_v | we_v) & ~exp_hold;
        for (int p = 0; p < 2; p++) begin
            if (served[p] && en_v[p]) begin
                it.port = p;
                it.exp0 = model[addr[p]];
                it.exp1 = we_v[p] ? merge(model[addr[p]], wdata[p], ben[p]) : model[addr[p]];
                sb.push_back(it);
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (served[p] && we_v[p]) model[addr[p]] = merge(model[addr[p]], wdata[p], ben[p]);
        end
        @(posedge clk); #1;
        check_outputs(tag, served & en_v);
    endtask

    task automatic reset_cycle(input string tag, input logic [1:0] en_v, input logic [1:0] we_v,
                               input logic [5:0] a0, input logic [5:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1);
        rst = 1'b1; en = en_v; we = we_v;
        addr[0] = a0; addr[1] = a1; wdata[0] = d0; wdata[1] = d1; ben[0] = 4'hF; ben[1] = 4'hF;
        #1;
        chk({tag, "/hold_old"}, 32'(hold0), 32'd0);
        chk({tag, "/hold_new"}, 32'(hold1), 32'd0);
        @(posedge clk); #1;
        last0 = '0;
        last1 = '0;
        check_outputs(tag, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = '0; we = '0; addr = '0; wdata = '0; ben = '0;
        last0 = '0; last1 = '0;

        // reset with conflicting requests asserted: no hold, no valid, zero data
        reset_cycle("rst1", 2'b11, 2'b00, 6'd2, 6'd6, 32'h0, 32'h0);
        reset_cycle("rst2", 2'b11, 2'b00, 6'd2, 6'd6, 32'h0, 32'h0);

        // parallel access on different banks
        cycle("par_wr", 2'b00, 2'b11, 6'd4, 6'd5, 32'hDEADBEEF, 32'h12345678, 4'hF, 4'hF, 2'b00);
        cycle("par_rd", 2'b11, 2'b00, 6'd4, 6'd5, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);

        // preload words used later
        cycle("pre_a", 2'b00, 2'b11, 6'd2, 6'd7, 32'h22222222, 32'h77777777, 4'hF, 4'hF, 2'b00);
        cycle("pre_b", 2'b00, 2'b11, 6'd6, 6'd3, 32'h66666666, 32'h00000000, 4'hF, 4'hF, 2'b00);

        // bank-2 conflict: round-robin alternates starting with port 0
        cycle("conf1", 2'b11, 2'b00, 6'd2, 6'd6, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10);
        cycle("conf2", 2'b11, 2'b00, 6'd2, 6'd6, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01);
        cycle("conf3", 2'b11, 2'b00, 6'd2, 6'd6, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10);

        // byte enables, including an all-zero mask on port 1
        cycle("be_full", 2'b00, 2'b11, 6'd9, 6'd7, 32'hAABBCCDD, 32'hFFFFFFFF, 4'hF, 4'h0, 2'b00);
        cycle("be_part", 2'b00, 2'b01, 6'd9, 6'd0, 32'h11223344, 32'h0, 4'h5, 4'h0, 2'b00);
        cycle("be_rd", 2'b11, 2'b00, 6'd9, 6'd7, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);

        // same-port read-during-write on addr 3 (holds 0)
        cycle("rdw", 2'b10, 2'b10, 6'd0, 6'd3, 32'h0, 32'h00000055, 4'h0, 4'hF, 2'b00);
        cycle("rdw_after", 2'b10, 2'b00, 6'd0, 6'd3, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);

        // reset while port 1 is stalled on bank 1
        cycle("pre_c", 2'b00, 2'b01, 6'd1, 6'd0, 32'h01010101, 32'h0, 4'hF, 4'h0, 2'b00);
        cycle("pre_d", 2'b00, 2'b10, 6'd0, 6'd13, 32'h0, 32'h13131313, 4'h0, 4'hF, 2'b00);
        cycle("stall", 2'b01, 2'b10, 6'd1, 6'd13, 32'h0, 32'hBADBAD00, 4'h0, 4'hF, 2'b10);
        reset_cycle("rst_mid", 2'b01, 2'b10, 6'd1, 6'd13, 32'h0, 32'hBADBAD00);
        cycle("post1", 2'b11, 2'b00, 6'd1, 6'd13, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10);
        cycle("post2", 2'b11, 2'b00, 6'd1, 6'd13, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01);

        en = '0; we = '0;
        @(posedge clk); #1;
        check_outputs("idle", 2'b00);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
